riscv_keypad_scanner: RTL and testbench
=======================================

RISCV_KEYPAD_SCANNER -- requirements
Module: riscv_keypad_scanner

Interface
REQ-001 Parameter ROWS, default 4, number of row drive lines (2..8).
REQ-002 Parameter COLS, default 4, number of column sense lines (2..8).
REQ-003 Parameter SCAN_DIV, default 1000, settle cycles per row slot (>=4).
REQ-004 Parameter DEBOUNCE_SCANS, default 4, consecutive full scans needed to accept a change (1..15).
REQ-005 Parameter FIFO_DEPTH, default 8, event FIFO entries (power of two, >=2).
REQ-006 Derived: KW = clog2(ROWS*COLS); the key index is row*COLS+col.
REQ-007 clk_100mhz  input  1  single clock; all state SHALL be in this domain.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 enable  input  1  scan enable; low SHALL park the scanner.
REQ-010 row_out  output  ROWS  active-low row drive; at most one bit SHALL be low at a time.
REQ-011 col_in  input  COLS  active-low column sense, asynchronous to clk_100mhz.
REQ-012 evt_valid  output  1  FIFO non-empty; evt_data is valid.
REQ-013 evt_data  output  KW+1  {press(1)/release(0), key index}, FIFO head.
REQ-014 evt_ready  input  1  pop the FIFO head when evt_valid && evt_ready.
REQ-015 key_state  output  ROWS*COLS  debounced pressed bitmap, indexed by key index.
REQ-016 irq  output  1  level interrupt, equal to evt_valid.
REQ-017 overflow  output  1  sticky flag set when an event is dropped.
REQ-018 ovf_clear  input  1  synchronous clear of overflow.

Function
REQ-019 col_in SHALL pass through a 2-flop synchronizer before any use.
REQ-020 FSM states: IDLE, SETTLE, EVAL.
- IDLE: row_out all ones; go to SETTLE with row 0 when enable=1.
- SETTLE: drive the current row low for SCAN_DIV cycles.
- EVAL: hold the row; process column c = 0..COLS-1, one per cycle; after the last column, advance the row (ROWS-1 wraps to 0) and enter SETTLE.
REQ-021 The row slot SHALL be exactly SCAN_DIV+COLS cycles, and a full scan exactly ROWS*(SCAN_DIV+COLS) cycles.
REQ-022 Per key in EVAL, with sample = !synced col_in[c]:
- sample == key_state: clear that key's debounce counter.
- Otherwise: increment the counter.
- When the counter reaches DEBOUNCE_SCANS: toggle key_state, clear the counter, and push the event {sample, index}.
REQ-023 Debounce counters SHALL be 4 bits per key and SHALL never exceed DEBOUNCE_SCANS.
REQ-024 At most one push and one pop SHALL occur per cycle.
REQ-025 Push when full without a pop: drop the event and set overflow the next cycle; key_state still updates.
REQ-026 Push and pop in the same cycle when full: both SHALL succeed, and count stays FIFO_DEPTH.
REQ-027 Pop when empty SHALL be ignored.
REQ-028 evt_data SHALL be stable while evt_valid && !evt_ready.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with a separate count or extra pointer bit for full/empty.
REQ-030 Overflow priority: a set and ovf_clear in the same cycle SHALL leave overflow = 1.
REQ-031 enable falling in any state:
- Next cycle: IDLE and row_out all ones.
- Debounce counters cleared.
- key_state and FIFO preserved.
- A re-enable restarts at row 0.
REQ-032 No combinational path SHALL exist from col_in or evt_ready to any output, except evt_valid/evt_data/irq reflecting the registered FIFO state.

Reset
REQ-033 While reset is high, state SHALL be forced asynchronously:
- row_out all ones; state IDLE; row index 0.
- Counters 0; key_state 0.
- FIFO empty (evt_valid 0, evt_data 0, irq 0); overflow 0.
REQ-034 Reset deassertion mid-scan SHALL restart cleanly from IDLE; no event SHALL be generated by the reset itself.

Verification (ROWS=4, COLS=4, SCAN_DIV=8, DEBOUNCE_SCANS=3, FIFO_DEPTH=4)
REQ-035 Reset asserted for 5 cycles, enable=1, col_in=4'hF:
- row_out = 4'hF during reset.
- After release, rows cycle E,D,B,7, each held 12 cycles.
- No events.
REQ-036 Key row1/col2 held low:
- After the 3rd qualifying scan, one event evt_data = 5'h16 and key_state[6] = 1.
- Release for 3 scans gives evt_data = 5'h06 and key_state[6] = 0.
REQ-037 Bounce, key index 6 pressed for 2 scans then released: no event, and key_state stays 0.
REQ-038 evt_ready=0, 5 distinct presses:
- The first 4 events are queued and overflow = 1.
- Popping 4 returns them in order, then evt_valid = 0.
- A ovf_clear pulse gives overflow = 0.
REQ-039 FIFO full and a push coincides with a pop: count stays 4, overflow stays 0, and the new event appears last.
REQ-040 enable dropped mid-SETTLE of row 2:
- Next cycle row_out = 4'hF.
- FIFO contents and key_state unchanged.
- Re-enable drives row 0 (4'hE) first.

Source files
------------

// File: rtl/riscv_keypad_scanner_if.sv
// Event handshake between the keypad scanner and its consumer.
//   evt_valid : event FIFO non-empty, evt_data holds the FIFO head
//   evt_data  : {press(1)/release(0), key index}
//   evt_ready : consumer accepts the head when evt_valid is high
// master = scanner side, slave = consumer side.
interface riscv_keypad_scanner_if #(
  parameter int unsigned DW = 5
) ();
  logic          evt_valid;
  logic [DW-1:0] evt_data;
  logic          evt_ready;

  modport master (
    output evt_valid,
    output evt_data,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_data,
    output evt_ready
  );
endinterface

// File: rtl/riscv_keypad_scanner.sv
// Matrix keypad scanner with per-key debounce and an event FIFO.
// Rows are driven low one at a time; after a settle period each column of the
// active row is evaluated, one per cycle. A key change is accepted only after
// DEBOUNCE_SCANS consecutive scans disagree with the debounced state.
// Ports:
//   clk_100mhz : single clock
//   reset      : asynchronous active-high reset
//   enable     : scan enable, low parks the scanner in IDLE
//   row_out    : active-low row drive (one-cold or all ones)
//   col_in     : active-low column sense, asynchronous
//   evt        : event handshake (master modport), head of the event FIFO
//   key_state  : debounced pressed bitmap, bit = row*COLS+col
//   irq        : level interrupt, mirrors evt_valid
//   overflow   : sticky, set when an event is dropped on a full FIFO
//   ovf_clear  : synchronous clear of overflow (a same-cycle set wins)
module riscv_keypad_scanner #(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic                     clk_100mhz,
  input  logic                     reset,
  input  logic                     enable,
  output logic [ROWS-1:0]          row_out,
  input  logic [COLS-1:0]          col_in,
  riscv_keypad_scanner_if.master   evt,
  output logic [ROWS*COLS-1:0]     key_state,
  output logic                     irq,
  output logic                     overflow,
  input  logic                     ovf_clear
);

  localparam int unsigned NKEYS = ROWS * COLS;
  localparam int unsigned KW    = $clog2(NKEYS);
  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned CW    = $clog2(COLS);
  localparam int unsigned DIVW  = $clog2(SCAN_DIV);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StSettle, StEval} state_e;

  // ---------------------------------------------------------------------------
  // Column synchronizer
  // ---------------------------------------------------------------------------
  logic [COLS-1:0] col_meta_q, col_sync_q;

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      col_meta_q <= '1;
      col_sync_q <= '1;
    end else begin
      col_meta_q <= col_in;
      col_sync_q <= col_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [DIVW-1:0] div_q, div_d;
  logic            eval_en;

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      div_q   <= div_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    div_d   = div_q;
    eval_en = 1'b0;
    if (!enable) begin
      // Parking always restarts the next scan from row 0.
      state_d = StIdle;
      row_d   = '0;
      col_d   = '0;
      div_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StSettle;
          row_d   = '0;
          col_d   = '0;
          div_d   = '0;
        end
        StSettle: begin
          if (div_q == DIVW'(SCAN_DIV - 1)) begin
            state_d = StEval;
            div_d   = '0;
            col_d   = '0;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        StEval: begin
          eval_en = 1'b1;
          if (col_q == CW'(COLS - 1)) begin
            col_d   = '0;
            state_d = StSettle;
            row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    row_out = '1;
    if (state_q != StIdle) row_out[row_q] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------
  logic [NKEYS-1:0] key_state_q;
  logic [3:0]       deb_q [NKEYS];
  logic [KW-1:0]    key_idx;
  logic             sample;
  logic             mismatch;
  logic             deb_hit;
  logic             push;
  logic [KW:0]      push_data;

  always_comb begin
    key_idx   = KW'(32'(row_q) * COLS + 32'(col_q));
    sample    = ~col_sync_q[col_q];
    mismatch  = sample != key_state_q[key_idx];
    // Counter holds DEBOUNCE_SCANS-1 disagreeing scans; this one completes the run.
    deb_hit   = mismatch && (deb_q[key_idx] == 4'(DEBOUNCE_SCANS - 1));
    push      = eval_en && deb_hit;
    push_data = {sample, key_idx};
  end

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      key_state_q <= '0;
      for (int i = 0; i < NKEYS; i++) deb_q[i] <= '0;
    end else if (!enable) begin
      for (int i = 0; i < NKEYS; i++) deb_q[i] <= '0;
    end else if (eval_en) begin
      if (!mismatch) begin
        deb_q[key_idx] <= '0;
      end else if (deb_hit) begin
        deb_q[key_idx]       <= '0;
        key_state_q[key_idx] <= sample;
      end else begin
        deb_q[key_idx] <= deb_q[key_idx] + 4'd1;
      end
    end
  end

  assign key_state = key_state_q;

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
  logic [KW:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          fifo_full, fifo_empty;
  logic          pop, wr_en, ovf_set;
  logic          overflow_q;

  always_comb begin
    fifo_empty = cnt_q == '0;
    fifo_full  = cnt_q == (AW + 1)'(FIFO_DEPTH);
    pop        = !fifo_empty && evt.evt_ready;
    // A pop frees the slot the push needs, so full-with-pop still accepts.
    wr_en      = push && (!fifo_full || pop);
    ovf_set    = push && fifo_full && !pop;
  end

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (ovf_set)        overflow_q <= 1'b1;
      else if (ovf_clear) overflow_q <= 1'b0;
    end
  end

  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_data  = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign irq           = !fifo_empty;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_riscv_keypad_scanner.sv
module tb_riscv_keypad_scanner;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int SDIV = 8;
  localparam int DEB  = 3;
  localparam int FD   = 4;
  localparam int SCAN = ROWS * (SDIV + COLS);

  logic        clk_100mhz = 1'b0;
  logic        reset      = 1'b1;
  logic        enable     = 1'b0;
  logic        ovf_clear  = 1'b0;
  logic [3:0]  row_out;
  logic [3:0]  col_in;
  logic [15:0] key_state;
  logic        irq;
  logic        overflow;
  logic [15:0] phys = '0;
  logic [15:0] ks_model = '0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0] exp_q [$];

  riscv_keypad_scanner_if #(.DW(5)) evt_if ();

  riscv_keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SDIV), .DEBOUNCE_SCANS(DEB), .FIFO_DEPTH(FD)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .enable     (enable),
    .row_out    (row_out),
    .col_in     (col_in),
    .evt        (evt_if),
    .key_state  (key_state),
    .irq        (irq),
    .overflow   (overflow),
    .ovf_clear  (ovf_clear)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  // Physical key matrix: a pressed key shorts its row to its column.
  always_comb begin
    col_in = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (phys[r*COLS+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted event is compared with the oldest expectation.
  always @(negedge clk_100mhz) begin
    if (!reset && evt_if.evt_valid && evt_if.evt_ready) begin
      n_cmp = n_cmp + 1;
      if (exp_q.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL evt_unexpected: got %0h, expected no event", evt_if.evt_data);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if (evt_if.evt_data !== e) begin
          n_bad = n_bad + 1;
          $display("FAIL evt_data: got %0h, expected %0h", evt_if.evt_data, e);
        end
      end
    end
  end

  task automatic wait_row(input logic [3:0] val, input string name);
    int n;
    n = 0;
    @(negedge clk_100mhz);
    while (row_out !== val && n < 4 * SCAN) begin
      @(negedge clk_100mhz);
      n++;
    end
    check(name, row_out, val);
  endtask

  task automatic wait_leave(input logic [3:0] val);
    int n;
    n = 0;
    @(negedge clk_100mhz);
    while (row_out === val && n < 2 * SCAN) begin
      @(negedge clk_100mhz);
      n++;
    end
  endtask

  // Change one key and hold it for a number of scans; qualifying changes
  // update the key model and, if the FIFO will take it, the scoreboard.
  task automatic apply(input int key, input logic val, input int scans, input logic exp_evt);
    phys[key] = val;
    if (exp_evt) exp_q.push_back({val, 4'(key)});
    if (scans >= DEB) ks_model[key] = val;
    repeat (scans * SCAN) @(posedge clk_100mhz);
    #1;
  endtask

  typedef struct {
    int          key;
    logic        val;
    int          scans;
    logic        has_evt;
    logic [15:0] exp_state;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [3:0] er;
    int         bad_row [4];

    vecs[0] = '{6,  1'b1, 4, 1'b1, 16'h0040};
    vecs[1] = '{6,  1'b0, 4, 1'b1, 16'h0000};
    vecs[2] = '{6,  1'b1, 2, 1'b0, 16'h0000};
    vecs[3] = '{6,  1'b0, 2, 1'b0, 16'h0000};
    vecs[4] = '{0,  1'b1, 4, 1'b1, 16'h0001};
    vecs[5] = '{15, 1'b1, 4, 1'b1, 16'h8001};
    vecs[6] = '{15, 1'b0, 4, 1'b1, 16'h0001};
    vecs[7] = '{0,  1'b0, 4, 1'b1, 16'h0000};
    vecs[8] = '{9,  1'b1, 1, 1'b0, 16'h0000};
    vecs[9] = '{9,  1'b0, 1, 1'b0, 16'h0000};

    evt_if.evt_ready = 1'b1;
    enable = 1'b1;

    // Reset state
    repeat (4) @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    check("rst_row_out", row_out, 4'hF);
    check("rst_evt_valid", evt_if.evt_valid, 1'b0);
    check("rst_evt_data", evt_if.evt_data, 5'h00);
    check("rst_irq", irq, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_key_state", key_state, 16'h0000);
    @(posedge clk_100mhz);
    #1 reset = 1'b0;

    // Row sequence E,D,B,7, 12 cycles each
    wait_leave(4'hF);
    for (int r = 0; r < 4; r++) bad_row[r] = 0;
    for (int i = 0; i < SCAN; i++) begin
      er = ~(4'b0001 << (i / 12));
      if (row_out !== er) bad_row[i / 12]++;
      @(negedge clk_100mhz);
    end
    for (int r = 0; r < 4; r++) check($sformatf("row_slot%0d_bad_cycles", r), bad_row[r], 0);
    check("idle_no_event", evt_if.evt_valid, 1'b0);

    // Table-driven press/release/bounce vectors
    for (int v = 0; v < 10; v++) begin
      apply(vecs[v].key, vecs[v].val, vecs[v].scans, vecs[v].has_evt);
      @(negedge clk_100mhz);
      check($sformatf("vec%0d_key_state", v), key_state, vecs[v].exp_state);
      check($sformatf("vec%0d_pending", v), exp_q.size(), 0);
    end

    // Overflow: five presses with the consumer stalled
    evt_if.evt_ready = 1'b0;
    for (int k = 1; k <= 5; k++) apply(k, 1'b1, 4, k <= FD);
    @(negedge clk_100mhz);
    check("ovf_set", overflow, 1'b1);
    check("ovf_key_state", key_state, ks_model);
    check("ovf_head", evt_if.evt_data, 5'h11);
    check("ovf_irq", irq, 1'b1);

    // Enable dropped mid-SETTLE of row 2
    wait_leave(4'hB);
    wait_row(4'hB, "find_row2");
    @(posedge clk_100mhz);
    #1 enable = 1'b0;
    @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    check("dis_row_out", row_out, 4'hF);
    repeat (20) @(negedge clk_100mhz);
    check("dis_row_parked", row_out, 4'hF);
    check("dis_key_state", key_state, ks_model);
    check("dis_head", evt_if.evt_data, 5'h11);
    check("dis_valid", evt_if.evt_valid, 1'b1);
    @(posedge clk_100mhz);
    #1 enable = 1'b1;
    wait_leave(4'hF);
    check("reen_first_row", row_out, 4'hE);

    // Drain in order, then clear overflow
    evt_if.evt_ready = 1'b1;
    repeat (10) @(negedge clk_100mhz);
    check("drain_pending", exp_q.size(), 0);
    check("drain_valid", evt_if.evt_valid, 1'b0);
    check("drain_ovf_sticky", overflow, 1'b1);
    @(posedge clk_100mhz);
    #1 ovf_clear = 1'b1;
    @(posedge clk_100mhz);
    #1 ovf_clear = 1'b0;
    @(negedge clk_100mhz);
    check("ovf_cleared", overflow, 1'b0);

    // Full FIFO with a push and pop in the same cycle
    evt_if.evt_ready = 1'b0;
    for (int k = 1; k <= 4; k++) apply(k, 1'b0, 4, 1'b1);
    @(negedge clk_100mhz);
    check("full_valid", evt_if.evt_valid, 1'b1);
    check("full_head", evt_if.evt_data, 5'h01);
    wait_leave(4'hE);
    wait_row(4'hE, "find_row0");
    phys[5] = 1'b0;
    exp_q.push_back(5'h05);
    ks_model[5] = 1'b0;
    for (int s = 0; s < DEB; s++) begin
      wait_row(4'hD, "find_row1");
      if (s < DEB - 1) wait_leave(4'hD);
    end
    // Key 5 (col 1) is evaluated in slot cycle SDIV+1 of row 1.
    repeat (SDIV + 1) @(posedge clk_100mhz);
    #1 evt_if.evt_ready = 1'b1;
    @(posedge clk_100mhz);
    #1 evt_if.evt_ready = 1'b0;
    @(negedge clk_100mhz);
    check("coin_overflow", overflow, 1'b0);
    check("coin_key_state", key_state, ks_model);
    check("coin_head", evt_if.evt_data, 5'h02);
    evt_if.evt_ready = 1'b1;
    repeat (10) @(negedge clk_100mhz);
    check("coin_pending", exp_q.size(), 0);
    check("coin_drained", evt_if.evt_valid, 1'b0);

    // Reset mid-scan with a key held
    phys[9] = 1'b1;
    repeat (2 * SCAN + 5) @(posedge clk_100mhz);
    #1 reset = 1'b1;
    phys[9] = 1'b0;
    @(negedge clk_100mhz);
    check("mid_rst_row_out", row_out, 4'hF);
    check("mid_rst_key_state", key_state, 16'h0000);
    @(posedge clk_100mhz);
    #1 reset = 1'b0;
    repeat (2 * SCAN) @(negedge clk_100mhz);
    check("post_rst_no_event", evt_if.evt_valid, 1'b0);
    check("post_rst_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
